turn_controller: RTL and testbench
==================================

// Module: turn_controller
// PURPOSE
//  Move sequencer directly upstream of the board register (Matriz).
//  - Accepts a player-selected cell and a confirm pulse, and validates the move against the current board.
//  - Drives the pos/jugador/colocar request to the board and waits for colocado.
//  - Alternates players and ends the game on win from the winner detector (Ganador), or on a full board.
// PARAMETERS
//  N_CELLS      9    board cells; pos range 0..N_CELLS-1
//  WIN_LAT      1    cycles from colocado until win reflects the new board
//  TIMEOUT_CYC  500  idle cycles before auto-move (used only with TURN_TIMEOUT_EN)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  start      in   1     1-cycle pulse, begins game from IDLE
//  pos_in     in   4     cell selected by current player
//  confirm    in   1     1-cycle pulse, commit pos_in
//  board      in   9x2   cell state from board; 2'b00 = empty, 2'b01 = player 0, 2'b10 = player 1
//  colocado   in   1     board ack, high >=1 cycle after write
//  win        in   1     winner detector output
//  pos        out  4     cell to write
//  jugador    out  1     player owning the request / current turn
//  colocar    out  1     write request to board
//  invalid    out  1     1-cycle pulse, rejected confirm
//  game_over  out  1     sticky until reset
//  draw       out  1     sticky; full board without win
//  winner     out  1     valid when game_over && !draw
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; all outputs 0; move_cnt=0; jugador=0.
//  - States:
//    - IDLE: start -> WAIT_MOVE.
//    - WAIT_MOVE: confirm with pos_in<N_CELLS and board[pos_in]==00 -> latch pos, go to PLACE.
//      Any other confirm -> invalid=1 next cycle, stay.
//    - PLACE: colocar=1 (registered), pos/jugador stable -> WAIT_ACK.
//    - WAIT_ACK: colocar held 1 until colocado seen. On colocado: colocar=0 same edge, move_cnt++, go to CHECK.
//    - CHECK: wait WIN_LAT cycles, then:
//      - win=1 -> GAME_OVER, winner=jugador.
//      - else move_cnt==N_CELLS -> GAME_OVER, draw=1.
//      - else toggle jugador -> WAIT_MOVE.
//    - GAME_OVER: absorbing; confirm/start ignored (no invalid pulse); only rst leaves.
//  - Latency: confirm -> colocar high = 2 cycles; colocado -> next turn accepted = WIN_LAT+1 cycles.
//  - confirm outside WAIT_MOVE: ignored, no invalid pulse.
//  - confirm coincident with start in IDLE: only start acts.
//  - colocado while not in WAIT_ACK: ignored.
//  - move_cnt is 4 bits, saturates at N_CELLS; never wraps.
//  - rst mid-handshake (colocar=1): colocar drops asynchronously; no partial state retained.
// CONFIGURATION
//  TURN_TIMEOUT_EN defined:
//    - Counter runs in WAIT_MOVE and clears on any state change or invalid confirm.
//    - At TIMEOUT_CYC-1 with no valid confirm: pos = lowest-index empty cell, go to PLACE as a normal move.
//  TURN_TIMEOUT_EN undefined:
//    - No counter logic.
//    - WAIT_MOVE waits indefinitely.
// STRUCTURE
//  - Package tictactoe_pkg holds:
//    - typedef enum ctrl_state_t {IDLE, WAIT_MOVE, PLACE, WAIT_ACK, CHECK, GAME_OVER}
//    - cell_t (2-bit) and constants CELL_EMPTY/CELL_P0/CELL_P1
//    - N_CELLS_C
//  - Sub-module turn_timer: down-counter with load/clear/expire.
//    - Instantiated only under TURN_TIMEOUT_EN.
//    - Also contains a priority encoder for the lowest-index empty cell.
// TESTING
//  - Use the real Matriz and Ganador as board and winner detector.
//  - Scenarios:
//    1. rst=0 for 2 cycles, then start -> all outputs 0, then WAIT_MOVE. pos_in=4 + confirm -> 2 cycles later colocar=1, pos=4, jugador=0.
//    2. P0 plays 0,1,2 while P1 plays 3,4 (interleaved) -> game_over=1, winner=0, draw=0 after the 5th ack + WIN_LAT. Further confirm gives no invalid pulse.
//    3. confirm pos_in=4 when cell 4 occupied, then pos_in=9 -> two 1-cycle invalid pulses; jugador unchanged; no colocar.
//    4. Nine moves with no line (0,1,2,4,3,5,7,6,8) -> draw=1, game_over=1, move_cnt=9.
//    5. Hold colocado low for 20 cycles -> colocar stays 1, pos stable. Assert rst mid-wait -> colocar=0 immediately, state IDLE.
//    6. With TURN_TIMEOUT_EN, TIMEOUT_CYC=8, cells 0-2 full: no confirm -> colocar=1, pos=3, 8 cycles after entering WAIT_MOVE. Without the macro, no colocar after 1000 cycles.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencer.
//   ctrl_state_t : turn controller FSM states
//   cell_t       : 2-bit board cell encoding (empty / player 0 / player 1)
//   N_CELLS_C    : number of board cells
package tictactoe_pkg;

    localparam int N_CELLS_C = 9;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_P0    = 2'b01;
    localparam cell_t CELL_P1    = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_MOVE,
        PLACE,
        WAIT_ACK,
        CHECK,
        GAME_OVER
    } ctrl_state_t;

endpackage

// File: rtl/turn_controller_if.sv
// Board-side bus between the turn controller and the board register /
// winner detector.
//   pos      : cell to write
//   jugador  : player owning the request / current turn
//   colocar  : write request to the board
//   colocado : board acknowledge
//   board    : current cell states
//   win      : winner detector output
// master = turn controller, slave = board + winner detector.
interface turn_controller_if
    import tictactoe_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_C
);
    logic [3:0]              pos;
    logic                    jugador;
    logic                    colocar;
    logic                    colocado;
    cell_t [N_CELLS-1:0]     board;
    logic                    win;

    modport master (
        output pos, jugador, colocar,
        input  colocado, board, win
    );

    modport slave (
        input  pos, jugador, colocar,
        output colocado, board, win
    );
endinterface

// File: rtl/turn_timer.sv
// Idle-turn timer used for automatic moves (built only with TURN_TIMEOUT_EN).
//   clk, rst  : clock, asynchronous active-low reset
//   load      : reload the down-counter (state change or rejected confirm)
//   board     : current cell states
//   expire    : idle time used up and an empty cell exists
//   empty_pos : lowest-index empty cell
// The counter is reloaded with TIMEOUT_CYC-2 so that, counting the cycle in
// which WAIT_MOVE is entered, the automatic move leaves WAIT_MOVE on the
// TIMEOUT_CYC-1'th edge and colocar rises TIMEOUT_CYC cycles after entry.
module turn_timer
    import tictactoe_pkg::*;
#(
    parameter int N_CELLS     = N_CELLS_C,
    parameter int TIMEOUT_CYC = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  cell_t [N_CELLS-1:0] board,
    output logic                expire,
    output logic [3:0]          empty_pos
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          any_empty;

    always_comb begin
        if (load) begin
            cnt_d = CW'(TIMEOUT_CYC - 2);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= CW'(TIMEOUT_CYC - 2);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Scan from the top so the lowest empty index wins.
    always_comb begin
        empty_pos = '0;
        any_empty = 1'b0;
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (board[i] == CELL_EMPTY) begin
                empty_pos = 4'(i);
                any_empty = 1'b1;
            end
        end
    end

    assign expire = (cnt_q == '0) && any_empty;

endmodule

// File: rtl/turn_controller.sv
// Move sequencer in front of the board register.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : begins a game from IDLE
//   pos_in     : cell selected by the current player
//   confirm    : commit pos_in
//   bus        : board-side request/ack bus (pos, jugador, colocar,
//                colocado, board, win)
//   invalid    : 1-cycle pulse for a rejected confirm
//   game_over  : sticky until reset
//   draw       : sticky, full board without a win
//   winner     : winning player, valid when game_over && !draw
// Optional feature: define TURN_TIMEOUT_EN to auto-play the lowest empty
// cell after TIMEOUT_CYC idle cycles in WAIT_MOVE.
module turn_controller
    import tictactoe_pkg::*;
#(
    parameter int N_CELLS = N_CELLS_C,
    parameter int WIN_LAT = 1
`ifdef TURN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 500
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        pos_in,
    input  logic              confirm,
    turn_controller_if.master bus,
    output logic              invalid,
    output logic              game_over,
    output logic              draw,
    output logic              winner
);
    localparam int LW = (WIN_LAT > 1) ? $clog2(WIN_LAT) : 1;

    ctrl_state_t   state_q, state_d;
    logic [3:0]    pos_q, pos_d;
    logic          jug_q, jug_d;
    logic          colocar_q, colocar_d;
    logic          invalid_q, invalid_d;
    logic          over_q, over_d;
    logic          draw_q, draw_d;
    logic          winner_q, winner_d;
    logic [3:0]    move_cnt_q, move_cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          cell_ok;

    // Confirmed cell must be on the board and empty; out-of-range pos_in
    // never matches any index.
    always_comb begin
        cell_ok = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (pos_in == 4'(i) && bus.board[i] == CELL_EMPTY) begin
                cell_ok = 1'b1;
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    logic       tmr_load;
    logic       tmr_expire;
    logic [3:0] tmr_pos;

    assign tmr_load = (state_q != WAIT_MOVE) || (confirm && !cell_ok);

    turn_timer #(
        .N_CELLS     (N_CELLS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .board     (bus.board),
        .expire    (tmr_expire),
        .empty_pos (tmr_pos)
    );
`endif

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        jug_d      = jug_q;
        colocar_d  = colocar_q;
        invalid_d  = 1'b0;
        over_d     = over_q;
        draw_d     = draw_q;
        winner_d   = winner_q;
        move_cnt_d = move_cnt_q;
        lat_d      = lat_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                if (confirm) begin
                    if (cell_ok) begin
                        pos_d   = pos_in;
                        state_d = PLACE;
                    end else begin
                        invalid_d = 1'b1;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                else if (tmr_expire) begin
                    pos_d   = tmr_pos;
                    state_d = PLACE;
                end
`endif
            end
            PLACE: begin
                colocar_d = 1'b1;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.colocado) begin
                    colocar_d = 1'b0;
                    lat_d     = '0;
                    state_d   = CHECK;
                    if (move_cnt_q != 4'(N_CELLS)) begin
                        move_cnt_d = move_cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                // Give the winner detector WIN_LAT cycles to see the new cell.
                if (lat_q == LW'(WIN_LAT - 1)) begin
                    if (bus.win) begin
                        over_d   = 1'b1;
                        winner_d = jug_q;
                        state_d  = GAME_OVER;
                    end else if (move_cnt_q == 4'(N_CELLS)) begin
                        over_d  = 1'b1;
                        draw_d  = 1'b1;
                        state_d = GAME_OVER;
                    end else begin
                        jug_d   = ~jug_q;
                        state_d = WAIT_MOVE;
                    end
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            GAME_OVER: begin
                state_d = GAME_OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pos_q      <= '0;
            jug_q      <= 1'b0;
            colocar_q  <= 1'b0;
            invalid_q  <= 1'b0;
            over_q     <= 1'b0;
            draw_q     <= 1'b0;
            winner_q   <= 1'b0;
            move_cnt_q <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            jug_q      <= jug_d;
            colocar_q  <= colocar_d;
            invalid_q  <= invalid_d;
            over_q     <= over_d;
            draw_q     <= draw_d;
            winner_q   <= winner_d;
            move_cnt_q <= move_cnt_d;
            lat_q      <= lat_d;
        end
    end

    assign bus.pos     = pos_q;
    assign bus.jugador = jug_q;
    assign bus.colocar = colocar_q;
    assign invalid     = invalid_q;
    assign game_over   = over_q;
    assign draw        = draw_q;
    assign winner      = winner_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: a board/winner responder, a timestamp-based
// game model, a per-cycle compare process, directed scenarios with literal
// expectations, and randomized games.
`timescale 1ns/1ps
module tb_turn_controller;
    import tictactoe_pkg::*;

    localparam int WIN_LAT = 1;
`ifdef TURN_TIMEOUT_EN
    localparam int TO_CYC = 8;
`endif
    localparam int LINES [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                                    '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       confirm = 1'b0;
    logic [3:0] pos_in = 4'd0;
    logic       invalid, game_over, draw, winner;

    cell_t [8:0] board_r = '0;
    logic        colocado_r = 1'b0;
    logic        hold_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    turn_controller_if bus ();

    function automatic logic line_win(input cell_t [8:0] b);
        for (int l = 0; l < 8; l++) begin
            if (b[LINES[l][0]] != CELL_EMPTY && b[LINES[l][0]] == b[LINES[l][1]] &&
                b[LINES[l][0]] == b[LINES[l][2]]) return 1'b1;
        end
        return 1'b0;
    endfunction

    assign bus.board    = board_r;
    assign bus.colocado = colocado_r;
    assign bus.win      = line_win(board_r);

`ifdef TURN_TIMEOUT_EN
    turn_controller #(.N_CELLS(9), .WIN_LAT(WIN_LAT), .TIMEOUT_CYC(TO_CYC)) dut (
`else
    turn_controller #(.N_CELLS(9), .WIN_LAT(WIN_LAT)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pos_in    (pos_in),
        .confirm   (confirm),
        .bus       (bus),
        .invalid   (invalid),
        .game_over (game_over),
        .draw      (draw),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural game model ----------------
    int e = 0;
    bit m_started, m_over, m_draw, m_winner, m_jug, m_busy, m_acked, m_inv, m_colocar;
    int m_pos, m_moves, m_accept_e, m_decide_e, m_idle_e;

    task automatic model_reset();
        m_started = 0; m_over = 0; m_draw = 0; m_winner = 0; m_jug = 0;
        m_busy = 0; m_acked = 0; m_inv = 0; m_colocar = 0;
        m_pos = 0; m_moves = 0; m_accept_e = 0; m_decide_e = 0; m_idle_e = 0;
    endtask

    function automatic int first_empty(input cell_t [8:0] b);
        for (int i = 0; i < 9; i++) if (b[i] == CELL_EMPTY) return i;
        return -1;
    endfunction

    task automatic accept(input int p);
        m_busy = 1; m_acked = 0; m_pos = p; m_accept_e = e;
    endtask

    // Applied once per rising edge with the inputs sampled at that edge.
    task automatic model_step();
        int idx;
        idx = int'(pos_in);
        m_inv = 0;
        if (!m_started) begin
            if (start) begin m_started = 1; m_idle_e = e; end
        end else if (m_over) begin
        end else if (!m_busy) begin
            if (confirm) begin
                if (idx < 9 && bus.board[idx] == CELL_EMPTY) accept(idx);
                else begin m_inv = 1; m_idle_e = e; end
            end
`ifdef TURN_TIMEOUT_EN
            else if (e - m_idle_e == TO_CYC - 1 && first_empty(bus.board) >= 0) begin
                accept(first_empty(bus.board));
            end
`endif
        end else if (!m_acked) begin
            if (e >= m_accept_e + 2 && bus.colocado) begin
                m_acked = 1;
                if (m_moves < 9) m_moves++;
                m_decide_e = e + WIN_LAT;
            end
        end else if (e == m_decide_e) begin
            if (bus.win) begin m_over = 1; m_winner = m_jug; end
            else if (m_moves == 9) begin m_over = 1; m_draw = 1; end
            else begin m_jug = !m_jug; m_busy = 0; m_acked = 0; m_idle_e = e; end
        end
        m_colocar = m_busy && !m_acked && (e >= m_accept_e + 1);
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk);
            e++;
            if (rst) model_step();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            #1;
            if (!rst) model_reset();
            chk("cyc_colocar", bus.colocar, m_colocar);
            chk("cyc_pos", bus.pos, m_pos);
            chk("cyc_jugador", bus.jugador, m_jug);
            chk("cyc_invalid", invalid, m_inv);
            chk("cyc_game_over", game_over, m_over);
            chk("cyc_draw", draw, m_draw);
            chk("cyc_winner", winner, m_winner);
        end
    end

    // ---------------- board register / ack responder ----------------
    initial begin : matriz
        int dcnt, dly;
        dcnt = 0; dly = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                board_r = '0; colocado_r = 1'b0; dcnt = 0;
            end else if (colocado_r) begin
                colocado_r = 1'b0;
            end else if (bus.colocar && !hold_ack) begin
                if (dcnt >= dly) begin
                    if (bus.pos < 4'd9) board_r[bus.pos] = bus.jugador ? CELL_P1 : CELL_P0;
                    colocado_r = 1'b1;
                    dcnt = 0;
                    dly = $urandom_range(0, 2);
                end else begin
                    dcnt++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; start = 1'b0; confirm = 1'b0; hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_start(input bit with_confirm);
        @(negedge clk);
        start = 1'b1; confirm = with_confirm; pos_in = 4'($urandom_range(0, 8));
        @(negedge clk);
        start = 1'b0; confirm = 1'b0;
    endtask

    task automatic pulse(input int p);
        @(negedge clk);
        pos_in = 4'(p); confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
    endtask

    task automatic wait_turn();
        int n;
        for (n = 0; n < 200; n++) begin
            if (m_over || !m_busy) break;
            @(negedge clk);
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL wait_turn: turn still busy after %0d cycles, expected completion", n);
        end
    endtask

    task automatic play(input int p);
        pulse(p);
        wait_turn();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int moves_a [5];
        int moves_d [9];
        int n;
        bit saw;
        moves_a = '{0, 3, 1, 4, 2};
        moves_d = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

        // Scenario 1: reset values, first move latency
        repeat (2) @(negedge clk);
        #1;
        chk("rst_colocar", bus.colocar, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_invalid", invalid, 0);
        chk("rst_jugador", bus.jugador, 0);
        rst = 1'b1;
        do_start(1'b0);
        pulse(4);
        #1;
        chk("s1_colocar_early", bus.colocar, 0);
        @(negedge clk); #1;
        chk("s1_colocar", bus.colocar, 1);
        chk("s1_pos", bus.pos, 4);
        chk("s1_jugador", bus.jugador, 0);
        wait_turn();

        // Scenario 2: player 0 wins on the top row
        do_reset();
        do_start(1'b0);
        foreach (moves_a[i]) play(moves_a[i]);
        #1;
        chk("s2_game_over", game_over, 1);
        chk("s2_winner", winner, 0);
        chk("s2_draw", draw, 0);
        pulse(5);
        #1;
        chk("s2_no_invalid", invalid, 0);

        // Scenario 3: occupied and out-of-range confirms
        do_reset();
        do_start(1'b0);
        play(4);
        pulse(4);
        #1;
        chk("s3_inv_occupied", invalid, 1);
        @(negedge clk); #1;
        chk("s3_inv_pulse_end", invalid, 0);
        pulse(9);
        #1;
        chk("s3_inv_range", invalid, 1);
        chk("s3_jugador", bus.jugador, 1);
        chk("s3_no_colocar", bus.colocar, 0);

        // Scenario 4: full board without a line
        do_reset();
        do_start(1'b0);
        foreach (moves_d[i]) play(moves_d[i]);
        #1;
        chk("s4_draw", draw, 1);
        chk("s4_game_over", game_over, 1);

        // Scenario 5: stalled ack, then reset mid-handshake
        do_reset();
        do_start(1'b0);
        hold_ack = 1'b1;
        pulse(6);
        repeat (20) @(negedge clk);
        #1;
        chk("s5_colocar_held", bus.colocar, 1);
        chk("s5_pos_stable", bus.pos, 6);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("s5_colocar_async", bus.colocar, 0);
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        pulse(2);
        #1;
        chk("s5_idle_no_invalid", invalid, 0);

        // Scenario 6: idle turn with cells 0-2 occupied
        do_reset();
        do_start(1'b0);
        play(0);
        play(1);
        play(2);
`ifdef TURN_TIMEOUT_EN
        n = 0;
        while (n < 50 && bus.colocar !== 1'b1) begin
            @(negedge clk); #1;
            n++;
        end
        chk("s6_auto_latency", n, TO_CYC);
        chk("s6_auto_pos", bus.pos, 3);
        wait_turn();
`else
        saw = 1'b0;
        repeat (1000) begin
            @(negedge clk); #1;
            if (bus.colocar) saw = 1'b1;
        end
        chk("s6_no_auto_move", saw, 0);
`endif

        // Randomized games
        for (int g = 0; g < 8; g++) begin
            do_reset();
            do_start(1'($urandom_range(0, 1)));
            for (int k = 0; k < 60 && !m_over; k++) begin
                int p;
                p = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                pulse(p);
                if ($urandom_range(0, 3) != 0) wait_turn();
                if ($urandom_range(0, 39) == 0) begin
                    do_reset();
                    do_start(1'b0);
                end
            end
            wait_turn();
            pulse($urandom_range(0, 8));
            repeat (3) @(negedge clk);
        end

        @(negedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
